// File: rtl/host_line_tx_if.sv
// Host byte-stream bus: line load request in, one byte per handshake out.
interface host_line_tx_if #(
   parameter int unsigned num_bits = 512
);
   localparam int unsigned NBYTES = num_bits / 8;
   localparam int unsigned IW     = $clog2(NBYTES);

   logic [num_bits-1:0] chunk_input;
   logic                load_en;
   logic                abort;
   logic                host_ready;
   logic [7:0]          byte_out;
   logic                byte_valid;
   logic [IW-1:0]       byte_index;
   logic                busy;
   logic                done_flag;

   // Driver side: supplies lines and host backpressure
   modport master (
      output chunk_input, load_en, abort, host_ready,
      input  byte_out, byte_valid, byte_index, busy, done_flag
   );

   // Transmitter side
   modport slave (
      input  chunk_input, load_en, abort, host_ready,
      output byte_out, byte_valid, byte_index, busy, done_flag
   );
endinterface

// File: rtl/host_line_tx.sv
// Serialises a captured line to the host one byte per handshake, byte 0 first.
module host_line_tx #(
   parameter int unsigned num_bits = 512
) (
   input  logic          clk,
   input  logic          rst,
   host_line_tx_if.slave bus
);
   localparam int unsigned NBYTES = num_bits / 8;
   localparam int unsigned IW     = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   // Remaining bytes, shifted down so the next byte always sits in [15:8]
   logic [num_bits-1:0] line;

   // Single-process FSM; every output is a register updated here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         line           <= '0;
         bus.byte_out   <= 8'h00;
         bus.byte_valid <= 1'b0;
         bus.byte_index <= '0;
         bus.busy       <= 1'b0;
         bus.done_flag  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done_flag <= 1'b0;
               if (bus.load_en) begin
                  state          <= SEND;
                  line           <= bus.chunk_input;
                  bus.byte_out   <= bus.chunk_input[7:0];
                  bus.byte_valid <= 1'b1;
                  bus.byte_index <= '0;
                  bus.busy       <= 1'b1;
               end
            end

            SEND: begin
               if (bus.abort) begin
                  // Offered byte is discarded even if host_ready is high
                  state          <= IDLE;
                  line           <= '0;
                  bus.byte_out   <= 8'h00;
                  bus.byte_valid <= 1'b0;
                  bus.byte_index <= '0;
                  bus.busy       <= 1'b0;
               end else if (bus.host_ready) begin
                  if (bus.byte_index == LAST_IDX) begin
                     state          <= DONE;
                     line           <= '0;
                     bus.byte_out   <= 8'h00;
                     bus.byte_valid <= 1'b0;
                     bus.byte_index <= '0;
                     bus.busy       <= 1'b0;
                     bus.done_flag  <= 1'b1;
                  end else begin
                     line           <= line >> 8;
                     bus.byte_out   <= line[15:8];
                     bus.byte_index <= bus.byte_index + IW'(1);
                  end
               end
            end

            DONE: begin
               // One-cycle completion pulse; load_en and abort ignored here
               state         <= IDLE;
               bus.done_flag <= 1'b0;
            end

            default: begin
               state          <= IDLE;
               line           <= '0;
               bus.byte_out   <= 8'h00;
               bus.byte_valid <= 1'b0;
               bus.byte_index <= '0;
               bus.busy       <= 1'b0;
               bus.done_flag  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/host_line_tx.md
HOST_LINE_TX -- requirements
Module: host_line_tx

Interface
REQ-001 Parameter num_bits, default 512, line width in bits; SHALL be a multiple of 8, with num_bits/8 a power of two and at least 2.
REQ-002 Derived constant NBYTES = num_bits/8 (64 at default); IW = log2(NBYTES) (6 at default).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 chunk_input  input  num_bits  line to send to host; sampled only at load acceptance.
REQ-006 load_en  input  1  request to start sending chunk_input, level-sampled each clk edge.
REQ-007 abort  input  1  synchronous cancel of an in-progress transfer.
REQ-008 host_ready  input  1  host can accept byte_out this cycle.
REQ-009 byte_out  output  8  current byte offered to host.
REQ-010 byte_valid  output  1  byte_out holds a valid byte.
REQ-011 byte_index  output  IW  index of byte currently offered (0..NBYTES-1).
REQ-012 busy  output  1  high while a line is held for transmission.
REQ-013 done_flag  output  1  one-cycle pulse after the final byte transfers.

Function
REQ-014 FSM states: IDLE, SEND, DONE; all outputs SHALL be registered.
REQ-015 IDLE: load_en=1 at an edge SHALL capture chunk_input into an internal line register, set byte_index=0, and enter SEND.
REQ-016 Load latency: byte_valid=1 and busy=1 with byte 0 on byte_out SHALL appear in the cycle immediately after the accepting edge.
REQ-017 Byte order: byte k SHALL equal captured line bits [8k+7:8k], sent in order k=0 first, k=NBYTES-1 last.
REQ-018 Transfer occurs at an edge where byte_valid=1 and host_ready=1; exactly one byte per transfer.
REQ-019 While byte_valid=1 and host_ready=0, byte_out and byte_index SHALL hold unchanged (no drop, no duplicate).
REQ-020 A transfer of byte k<NBYTES-1 SHALL advance byte_index to k+1 and byte_out to byte k+1 in the next cycle, valid remaining high (back-to-back, one byte per cycle with host_ready held high).
REQ-021 A transfer of byte NBYTES-1 SHALL enter DONE: byte_valid=0, busy=0, done_flag=1 for exactly one cycle, then IDLE.
REQ-022 Minimum line time with host_ready held high: NBYTES transfer cycles plus one DONE cycle (65 cycles at default from first valid to done_flag deassert).
REQ-023 load_en SHALL be ignored in SEND and DONE; chunk_input changes after capture SHALL not affect transmitted bytes.
REQ-024 abort=1 in SEND SHALL return to IDLE at that edge: byte_valid=0, busy=0, byte_index=0, no done_flag; a byte offered with host_ready=1 at that edge SHALL count as not transferred.
REQ-025 abort has priority over load_en and host_ready; abort in IDLE or DONE SHALL have no effect (a done_flag already high completes normally).
REQ-026 byte_index SHALL never exceed NBYTES-1; no wrap-around within one line.
REQ-027 In IDLE and DONE byte_out SHALL be 8'h00 and byte_index 0.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force IDLE, byte_out=0, byte_valid=0, byte_index=0, busy=0, done_flag=0, and clear the line register.
REQ-029 rst asserted mid-transfer SHALL discard the line; after release no bytes are offered until a new load_en.
REQ-030 First edge after rst deasserts SHALL behave as a normal IDLE edge, including load_en acceptance.

Verification
REQ-031 Load line with byte k = k (8'h00..8'h3F), host_ready held 1 -> bytes 00..3F in 64 consecutive valid cycles, byte_index 0..63, done_flag one cycle after byte 3F.
REQ-032 Same line, host_ready toggling 1-0-0-1 pseudo-randomly -> identical byte sequence, byte_out stable in every stall cycle, done_flag exactly once.
REQ-033 Change chunk_input to all-FF and pulse load_en during SEND -> transmitted bytes still 00..3F; second load ignored.
REQ-034 abort at byte_index 20 with host_ready=1 -> byte_valid=0 next cycle, no done_flag; new load restarts at byte_index 0.
REQ-035 Assert rst asynchronously between edges at byte_index 40 -> all outputs 0 before the next edge; no bytes after release until load_en.
REQ-036 load_en held high continuously -> lines sent back-to-back, each separated by exactly one DONE cycle and one IDLE acceptance edge.
